mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of the word-organised data RAM.
- The RAM has a combinational read, a synchronous word write, and takes a byte address that it divides by 4 internally.
- This block accepts byte, halfword and word load/store requests from the CPU memory stage using a valid/ready handshake.
- It performs sub-word stores as read-modify-write, extracts and extends sub-word loads, and returns one response per request.

Parameters:
- DEPTH, 128: words in the attached RAM; byte addresses at or above DEPTH*4 are out of range.
- AW, 32: address width; matches the RAM address port.
- DW, 32: data width; fixed at 32 because the lane logic assumes 4 byte lanes.

Ports:
- clk, input, 1: rising-edge clock, shared with the RAM.
- reset, input, 1: synchronous active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request (high only in IDLE).
- req_we, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned, input, 1: zero-extend a sub-word load; otherwise sign-extend.
- req_addr, input, AW: byte address.
- req_wdata, input, DW: store data, right-aligned.
- resp_valid, output, 1: one-cycle response pulse.
- resp_rdata, output, DW: extended load data; 0 for stores and errors.
- resp_err, output, 1: request rejected; no memory write occurred.
- mem_adr, output, AW: to RAM adr; word-aligned (low 2 bits 0).
- mem_we, output, 1: to RAM we.
- mem_din, output, DW: to RAM din.
- mem_dout, input, DW: from RAM dout (combinational read).

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_adr=0, mem_din=0.
- Reset mid-operation: the FSM returns to IDLE. mem_we is gated by !reset, so no write occurs during the reset cycle. The pending response is discarded.
- Byte order is little-endian: byte lane k = bits [8k+7:8k]. Lane = addr[1:0]; half lane = addr[1].
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: on req_valid && req_ready, latch the request into registers. mem_adr is driven from the latched address for the rest of the request.
  - Error request (size 11, addr >= DEPTH*4, or misaligned when checked) -> RESP with err=1.
  - Load -> LOAD.
  - Word store -> WRITE.
  - Byte/half store -> RMW_RD.
- LOAD: sample mem_dout, select the lane, extend per req_unsigned into resp_rdata -> RESP.
- RMW_RD: sample mem_dout into the merge register and overlay the store bytes on the selected lane(s) -> WRITE.
- WRITE: mem_we=1 for exactly one cycle; mem_din = merged word (word store: req_wdata) -> RESP.
- RESP: resp_valid=1 for one cycle with rdata/err held stable -> IDLE. req_ready is 0 in this state; there is no back-to-back accept.
- Latency (accept edge = T):
  - load: resp at T+2
  - word store: resp at T+2, write at T+1
  - sub-word store: resp at T+3, write at T+2
  - error: resp at T+1
- Only one request is outstanding. req_* inputs are ignored while not in IDLE.
- Boundaries:
  - Address DEPTH*4-4 is legal.
  - DEPTH*4 returns an error.
  - Unused upper address bits are still range-checked, with no wrap-around.

Optional Feature:
- Macro MEM_ACCESS_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 returns resp_err=1, performs no RAM access, and responds at T+1.
- Undefined: misaligned addresses are silently aligned down (half: clear addr[0]; word: clear addr[1:0]) and the access proceeds normally.

Decomposition:
- Package mem_access_pkg holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state encoding
  - lane-count constant
- Sub-module mem_lane_mux (combinational) provides:
  - store merge: old word, wdata, size, addr[1:0] -> new word
  - load extract: word, size, addr[1:0], unsigned -> extended data
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> one mem_we pulse at T+1 with mem_adr=0x10; load resp_rdata=0xDEADBEEF at T+2.
- With mem[0x10]=0xDEADBEEF, byte store 0x55 @0x12 -> RMW writes 0xDE55BEEF; a following word load returns 0xDE55BEEF.
- With mem[0x10]=0xDEADBEEF:
  - signed byte load @0x13 -> 0xFFFFFFDE
  - unsigned byte load @0x13 -> 0x000000DE
  - signed half load @0x10 -> 0xFFFFBEEF
- Load @0x1FC (DEPTH=128) succeeds.
- Load @0x200 -> resp_err=1 at T+1, no mem_we.
- req_size=11 -> resp_err=1, no mem_we.
- Half store @0x11:
  - with MEM_ACCESS_ALIGN_CHECK_EN -> resp_err=1, memory unchanged.
  - without -> writes the low half of word 0x10.
- Assert reset during the RMW_RD cycle of a byte store -> no mem_we pulse, no resp_valid, req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants for the load/store front-end: access size codes, FSM state
// encoding and byte-lane count.
package mem_access_pkg;

   localparam int unsigned LANES = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_RMW_RD = 3'd2;
   localparam logic [2:0] ST_WRITE  = 3'd3;
   localparam logic [2:0] ST_RESP   = 3'd4;

endpackage

// File: rtl/mem_lane_mux.sv
// Little-endian byte-lane steering: merges sub-word store data into an old
// word and extracts/extends sub-word load data.
module mem_lane_mux
   import mem_access_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] old_word,
   input  logic [DW-1:0] wdata,
   input  logic [1:0]    size,
   input  logic [1:0]    lane,
   input  logic          is_unsigned,
   input  logic [DW-1:0] rd_word,
   output logic [DW-1:0] merged,
   output logic [DW-1:0] rdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      merged = old_word;
      case (size)
         SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
         SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged = wdata;
      endcase
   end

   always_comb begin
      byte_sel = rd_word[{lane, 3'b000} +: 8];
      half_sel = rd_word[{lane[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: rdata = is_unsigned ? {{(DW-8){1'b0}}, byte_sel}
                                      : {{(DW-8){byte_sel[7]}}, byte_sel};
         SZ_HALF: rdata = is_unsigned ? {{(DW-16){1'b0}}, half_sel}
                                      : {{(DW-16){half_sel[15]}}, half_sel};
         default: rdata = rd_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-organised RAM with combinational read.
// Define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          resp_valid,
   output logic [DW-1:0] resp_rdata,
   output logic          resp_err,
   output logic [AW-1:0] mem_adr,
   output logic          mem_we,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH * 4);

   logic [2:0]    state;
   logic [1:0]    lat_size;
   logic          lat_uns;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] merge_q;
   logic [DW-1:0] rdata_q;
   logic          err_q;

   logic [AW-1:0] align_addr;
   logic          bad_align;
   logic          req_err;
   logic [DW-1:0] merged;
   logic [DW-1:0] ld_data;

   always_comb begin
      align_addr = req_addr;
      if (req_size == SZ_HALF) align_addr[0]   = 1'b0;
      if (req_size == SZ_WORD) align_addr[1:0] = 2'b00;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      bad_align = (req_size == SZ_HALF && req_addr[0]) ||
                  (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
      bad_align = 1'b0;
`endif
      // Full-width compare so high address bits never alias into range.
      req_err = (req_size == SZ_RSVD) || ({1'b0, req_addr} >= LIMIT) || bad_align;
   end

   // merge_q carries the store data until the RMW read overlays it on the old word.
   mem_lane_mux #(
      .DW(DW)
   ) u_lane_mux (
      .old_word    (mem_dout),
      .wdata       (merge_q),
      .size        (lat_size),
      .lane        (lat_addr[1:0]),
      .is_unsigned (lat_uns),
      .rd_word     (mem_dout),
      .merged      (merged),
      .rdata       (ld_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         lat_size <= SZ_BYTE;
         lat_uns  <= 1'b0;
         lat_addr <= '0;
         merge_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lat_size <= req_size;
                  lat_uns  <= req_unsigned;
                  lat_addr <= align_addr;
                  rdata_q  <= '0;
                  err_q    <= req_err;
                  if (req_we) merge_q <= req_wdata;
                  if (req_err)                  state <= ST_RESP;
                  else if (!req_we)             state <= ST_LOAD;
                  else if (req_size == SZ_WORD) state <= ST_WRITE;
                  else                          state <= ST_RMW_RD;
               end
            end
            ST_LOAD: begin
               rdata_q <= ld_data;
               state   <= ST_RESP;
            end
            ST_RMW_RD: begin
               merge_q <= merged;
               state   <= ST_WRITE;
            end
            ST_WRITE: state <= ST_RESP;
            ST_RESP:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_adr    = {lat_addr[AW-1:2], 2'b00};
   assign mem_we     = (state == ST_WRITE) && !reset;
   assign mem_din    = merge_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset corner sequences and
// randomized traffic against a byte-array reference memory.
module tb_mem_access_unit;

   localparam int DEPTH = 128;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_adr;
   logic        mem_we;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   logic [31:0] ram [DEPTH];
   logic        ram_clr;
   logic [7:0]  ref_mem [DEPTH*4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(
      .DEPTH(DEPTH),
      .AW(32),
      .DW(32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_adr      (mem_adr),
      .mem_we       (mem_we),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout)
   );

   // RAM model: combinational read, synchronous word write, byte address / 4.
   assign mem_dout = (mem_adr[31:2] < DEPTH) ? ram[mem_adr[8:2]] : 32'h0;

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= 32'h0;
      end else if (mem_we && mem_adr[31:2] < DEPTH) begin
         ram[mem_adr[8:2]] <= mem_din;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Reference: bytes in a flat array, access semantics from first principles.
   task automatic ref_apply(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output logic err,
                            output int lat, output int wlat, output logic [31:0] word);
      int nb;
      int base;
      logic [31:0] ea;
      logic mis;
      nb  = (sz == 2'd2) ? 4 : (sz == 2'd1) ? 2 : 1;
      mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
      err = (sz == 2'd3) || (addr >= 32'(DEPTH * 4));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      err = err || mis;
`endif
      ea   = addr & ~32'(nb - 1);
      rd   = 32'h0;
      word = 32'h0;
      wlat = 0;
      if (err) begin
         lat = 1;
      end else if (!we) begin
         for (int i = 0; i < nb; i++) rd = rd | (32'(ref_mem[int'(ea) + i]) << (8 * i));
         if (!uns && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8 * nb));
         lat = 2;
      end else begin
         for (int i = 0; i < nb; i++) ref_mem[int'(ea) + i] = wdata[8*i +: 8];
         lat  = (nb == 4) ? 2 : 3;
         wlat = lat - 1;
         base = int'(ea) & ~3;
         for (int i = 0; i < 4; i++) word = word | (32'(ref_mem[base + i]) << (8 * i));
      end
   endtask

   // One request: drive, accept, then watch the following cycles for write/response.
   task automatic do_req(input string nm, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic use_exp, input logic [31:0] exp_rd, input logic exp_err);
      logic [31:0] r_rd, r_word, w_adr, w_din, g_rd;
      logic r_err, g_err;
      int r_lat, r_wlat, got, wcnt, wcyc;
      ref_apply(we, sz, uns, addr, wdata, r_rd, r_err, r_lat, r_wlat, r_word);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      chk({nm, ".ready"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      // Busy-time garbage must be ignored until the unit is idle again.
      req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0; req_wdata = $urandom;
      got = 0; wcnt = 0; wcyc = 0; w_adr = 0; w_din = 0; g_rd = 0; g_err = 0;
      for (int c = 1; c <= 10 && got == 0; c++) begin
         @(negedge clk);
         if (mem_we) begin
            wcnt++; wcyc = c; w_adr = mem_adr; w_din = mem_din;
         end
         if (resp_valid) begin
            got = c; g_rd = resp_rdata; g_err = resp_err;
            chk({nm, ".ready_in_resp"}, 32'(req_ready), 32'd0);
         end
      end
      req_valid = 1'b0;
      chk({nm, ".resp_latency"}, 32'(got), 32'(r_lat));
      chk({nm, ".write_count"}, 32'(wcnt), (r_wlat != 0) ? 32'd1 : 32'd0);
      if (r_wlat != 0 && wcnt == 1) begin
         chk({nm, ".write_latency"}, 32'(wcyc), 32'(r_wlat));
         chk({nm, ".write_adr"}, w_adr, addr & 32'hFFFF_FFFC);
         chk({nm, ".write_data"}, w_din, r_word);
      end
      chk({nm, ".rdata"}, g_rd, use_exp ? exp_rd : r_rd);
      chk({nm, ".err"}, 32'(g_err), use_exp ? 32'(exp_err) : 32'(r_err));
   endtask

   // Reset asserted while the unit is mid-store; nothing may reach memory or the response port.
   task automatic reset_mid(input string nm, input logic [1:0] sz, input logic [31:0] addr);
      int seen_we, seen_resp;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = sz; req_unsigned = 1'b0;
      req_addr = addr; req_wdata = 32'hA5A5_A5A5;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk({nm, ".we_during_reset"}, 32'(mem_we), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk({nm, ".ready_after_reset"}, 32'(req_ready), 32'd1);
      chk({nm, ".resp_after_reset"}, 32'(resp_valid), 32'd0);
      seen_we = 0; seen_resp = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (mem_we) seen_we++;
         if (resp_valid) seen_resp++;
      end
      chk({nm, ".late_we"}, 32'(seen_we), 32'd0);
      chk({nm, ".late_resp"}, 32'(seen_resp), 32'd0);
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vt[$];

   function automatic void add(input logic we, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rd, input logic exp_err);
      vec_t v;
      v.we = we; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rd = exp_rd; v.exp_err = exp_err;
      vt.push_back(v);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      reset = 1'b1; ram_clr = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.req_ready",  32'(req_ready),  32'd1);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.resp_rdata", resp_rdata,      32'd0);
      chk("rst.resp_err",   32'(resp_err),   32'd0);
      chk("rst.mem_we",     32'(mem_we),     32'd0);
      chk("rst.mem_adr",    mem_adr,         32'd0);
      chk("rst.mem_din",    mem_din,         32'd0);
      reset = 1'b0; ram_clr = 1'b0;

      add(1, 2'd2, 0, 32'h10,  32'hDEAD_BEEF, 32'h0, 0);
      add(0, 2'd2, 0, 32'h10,  32'h0, 32'hDEAD_BEEF, 0);
      add(1, 2'd0, 0, 32'h12,  32'h0000_0055, 32'h0, 0);
      add(0, 2'd2, 0, 32'h10,  32'h0, 32'hDE55_BEEF, 0);
      add(1, 2'd2, 0, 32'h10,  32'hDEAD_BEEF, 32'h0, 0);
      add(0, 2'd0, 0, 32'h13,  32'h0, 32'hFFFF_FFDE, 0);
      add(0, 2'd0, 1, 32'h13,  32'h0, 32'h0000_00DE, 0);
      add(0, 2'd1, 0, 32'h10,  32'h0, 32'hFFFF_BEEF, 0);
      add(0, 2'd1, 1, 32'h12,  32'h0, 32'h0000_DEAD, 0);
      add(0, 2'd0, 0, 32'h10,  32'h0, 32'hFFFF_FFEF, 0);
      add(1, 2'd2, 0, 32'h1FC, 32'h1234_5678, 32'h0, 0);
      add(0, 2'd2, 0, 32'h1FC, 32'h0, 32'h1234_5678, 0);
      add(0, 2'd0, 0, 32'h1FF, 32'h0, 32'h0000_0012, 0);
      add(0, 2'd2, 0, 32'h200, 32'h0, 32'h0, 1);
      add(1, 2'd0, 0, 32'h200, 32'h0000_00AA, 32'h0, 1);
      add(0, 2'd3, 0, 32'h20,  32'h0, 32'h0, 1);
      add(1, 2'd3, 0, 32'h20,  32'h0000_FFFF, 32'h0, 1);
      add(0, 2'd2, 0, 32'h8000_0010, 32'h0, 32'h0, 1);
      add(0, 2'd2, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      add(1, 2'd1, 0, 32'h11,  32'h0000_ABCD, 32'h0, 1);
      add(0, 2'd2, 0, 32'h10,  32'h0, 32'hDEAD_BEEF, 0);
      add(0, 2'd2, 0, 32'h12,  32'h0, 32'h0, 1);
      add(1, 2'd0, 0, 32'h10,  32'hFFFF_FF5A, 32'h0, 0);
      add(0, 2'd2, 0, 32'h10,  32'h0, 32'hDEAD_BE5A, 0);
`else
      add(1, 2'd1, 0, 32'h11,  32'h0000_ABCD, 32'h0, 0);
      add(0, 2'd2, 0, 32'h10,  32'h0, 32'hDEAD_ABCD, 0);
      add(0, 2'd2, 0, 32'h12,  32'h0, 32'hDEAD_ABCD, 0);
      add(1, 2'd0, 0, 32'h10,  32'hFFFF_FF5A, 32'h0, 0);
      add(0, 2'd2, 0, 32'h10,  32'h0, 32'hDEAD_AB5A, 0);
`endif

      foreach (vt[i])
         do_req($sformatf("vec%0d", i), vt[i].we, vt[i].size, vt[i].uns, vt[i].addr,
                vt[i].wdata, 1'b1, vt[i].exp_rd, vt[i].exp_err);

      reset_mid("rst_rmw", 2'd0, 32'h20);
      do_req("rst_rmw.check", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0, 1'b0);
      reset_mid("rst_wr", 2'd2, 32'h24);
      do_req("rst_wr.check", 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b1, 32'h0, 1'b0);

      for (int n = 0; n < 300; n++) begin
         logic we, uns;
         logic [1:0] sz;
         logic [31:0] addr;
         int r;
         we  = 1'($urandom % 2);
         uns = 1'($urandom % 2);
         r   = int'($urandom % 8);
         sz  = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
         r   = int'($urandom % 10);
         if (r == 0)      addr = $urandom;
         else if (r == 1) addr = 32'($urandom_range(DEPTH * 4 - 8, DEPTH * 4 + 8));
         else             addr = $urandom % 64;
         do_req($sformatf("rnd%0d", n), we, sz, uns, addr, $urandom, 1'b0, 32'h0, 1'b0);
      end

      @(negedge clk);
      for (int k = 0; k < DEPTH; k++) begin
         w = {ref_mem[4*k+3], ref_mem[4*k+2], ref_mem[4*k+1], ref_mem[4*k]};
         chk($sformatf("ram%0d", k), ram[k], w);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
